ret_addr_stack: RTL and testbench
=================================

// Module: ret_addr_stack
// PURPOSE
//  Hardware return-address stack for the multi-cycle CA-2 datapath. On CALL the
//  controller pushes the 12-bit return PC; on RET it pops it. top_addr feeds the
//  PC-source mux directly upstream of the 12-bit PC register.
//  Storage is a DEPTH-entry LIFO with registered stack pointer; read is combinational.
// PARAMETERS
//  ADDR_W   12   width of a stored PC (matches PC register width)
//  DEPTH    8    number of entries; power of two, >=2
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  asynchronous, active-high reset
//  push       in   1                  store push_addr on this edge (CALL)
//  pop        in   1                  remove top entry on this edge (RET)
//  push_addr  in   ADDR_W             return address to store
//  top_addr   out  ADDR_W             current top entry; 0 when empty
//  empty      out  1                  count == 0
//  full       out  1                  count == DEPTH
//  count      out  $clog2(DEPTH+1)    number of valid entries
//  err        out  1                  sticky over/underflow flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-operation): count=0, all entries=0, err=0;
//    so top_addr=0, empty=1, full=0. Reset wins over push/pop on the same edge.
//  - State: sp = count (next free slot). top_addr = mem[sp-1] when !empty, else 0.
//  - top_addr/empty/full derived combinationally from registered state; a push is
//    visible on top_addr the cycle after the edge (latency 1), no same-cycle bypass.
//  - push only, !full: mem[sp] <= push_addr; sp <= sp+1.
//  - push only, full: entry dropped, mem/sp unchanged (overflow event).
//  - pop only, !empty: sp <= sp-1; popped entry left stale (not cleared).
//  - pop only, empty: no change (underflow event).
//  - push & pop, !empty: mem[sp-1] <= push_addr; sp unchanged (top replaced);
//    legal even when full, not an overflow.
//  - push & pop, empty: behaves as push only; not an underflow.
//  - Neither: hold. count never exceeds DEPTH nor wraps below 0.
//  - Write to mem and sp update occur on the same rising edge; no multi-cycle ops.
// CONFIGURATION
//  Macro RAS_ERR_FLAG_EN:
//  - defined: err set to 1 on the edge of any overflow or underflow event; stays
//    1 until rst. Stack state follows rules above regardless.
//  - undefined: err tied to 1'b0; no flag logic synthesised.
// STRUCTURE
//  - Package ca2_pkg: localparam PC_W=12; typedef logic [PC_W-1:0] pc_t;
//    typedef enum logic [1:0] {RAS_HOLD, RAS_PUSH, RAS_POP, RAS_REPL} ras_op_e
//    (op decode of {push,pop,empty,full}).
//  - Sub-module ras_mem: DEPTH x ADDR_W register array, one write port
//    (we, waddr, wdata), one async read port, async clear on rst.
//  - Top: op decode, sp register, flag register, output muxing.
// TESTING (DEPTH=8, ADDR_W=12)
//  - rst mid-stream after 3 pushes -> count=0, empty=1, top_addr=0x000, err=0
//    immediately (before next edge).
//  - push 0x101,0x202,0x303 -> count=3, top_addr=0x303; pop x3 -> top_addr
//    0x202,0x101,0x000; empty=1.
//  - 8 pushes 0x010..0x080 -> full=1; 9th push 0xFFF -> count=8, top_addr=0x080,
//    err=1 with RAS_ERR_FLAG_EN, err=0 without.
//  - pop on empty -> count stays 0, top_addr=0x000; err=1 iff macro defined.
//  - after push 0x0AA, push&pop 0x0BB -> count=1, top_addr=0x0BB; push&pop on
//    empty with 0x0CC -> count=1, top_addr=0x0CC, err=0.
//  - full stack, push&pop 0x123 -> count=8, top_addr=0x123, err unchanged.

Source files
------------

// File: rtl/ca2_pkg.sv
// Shared CA-2 datapath types: PC width and the return-address-stack op decode.
package ca2_pkg;

  localparam int PC_W = 12;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    RAS_HOLD,
    RAS_PUSH,
    RAS_POP,
    RAS_REPL
  } ras_op_e;

endpackage

// File: rtl/ras_mem.sv
// DEPTH x ADDR_W register array: one synchronous write port, one async read port,
// every entry cleared by the asynchronous reset.
module ras_mem #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// Return-address LIFO for CALL/RET; top_addr feeds the PC-source mux.
// Define RAS_ERR_FLAG_EN to build the sticky over/underflow err flag.
module ret_addr_stack
  import ca2_pkg::*;
#(
  parameter int ADDR_W = PC_W,
  parameter int DEPTH  = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top_addr,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [CNT_W-1:0]  sp;
  logic [PTR_W-1:0]  top_idx;
  logic [PTR_W-1:0]  waddr;
  logic [ADDR_W-1:0] rdata;
  ras_op_e           op;

  assign count   = sp;
  assign empty   = (sp == '0);
  assign full    = (sp == CNT_W'(DEPTH));
  assign top_idx = PTR_W'(sp - CNT_W'(1));

  // Simultaneous push/pop on an empty stack degrades to a plain push.
  always_comb begin
    op = RAS_HOLD;
    if (push && pop && !empty)
      op = RAS_REPL;
    else if (push && !full)
      op = RAS_PUSH;
    else if (pop && !push && !empty)
      op = RAS_POP;
  end

  assign waddr = (op == RAS_PUSH) ? sp[PTR_W-1:0] : top_idx;

  ras_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    ((op == RAS_PUSH) || (op == RAS_REPL)),
    .waddr (waddr),
    .wdata (push_addr),
    .raddr (top_idx),
    .rdata (rdata)
  );

  assign top_addr = empty ? '0 : rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else begin
      case (op)
        RAS_PUSH: sp <= sp + CNT_W'(1);
        RAS_POP:  sp <= sp - CNT_W'(1);
        default:  ;
      endcase
    end
  end

`ifdef RAS_ERR_FLAG_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if ((push && !pop && full) || (pop && !push && empty))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed self-checking bench for ret_addr_stack (DEPTH=8, ADDR_W=12).
module tb_ret_addr_stack;
  import ca2_pkg::*;

`ifdef RAS_ERR_FLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  pc_t        push_addr = '0;
  pc_t        top_addr;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  ret_addr_stack #(.ADDR_W(12), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .top_addr  (top_addr),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one operation across one rising edge; outputs are sampled 1 time unit later.
  task automatic cyc(input logic p, input logic q, input pc_t a);
    push      = p;
    pop       = q;
    push_addr = a;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_top",   32'(top_addr), 32'h000);
    chk("rst_err",   32'(err),   32'd0);

    // Basic push / pop ordering
    cyc(1, 0, 12'h101);
    chk("push1_top", 32'(top_addr), 32'h101);
    cyc(1, 0, 12'h202);
    cyc(1, 0, 12'h303);
    chk("push3_count", 32'(count), 32'd3);
    chk("push3_top",   32'(top_addr), 32'h303);
    cyc(0, 1, 12'h000);
    chk("pop1_top", 32'(top_addr), 32'h202);
    cyc(0, 1, 12'h000);
    chk("pop2_top", 32'(top_addr), 32'h101);
    cyc(0, 1, 12'h000);
    chk("pop3_top",   32'(top_addr), 32'h000);
    chk("pop3_empty", 32'(empty), 32'd1);
    chk("pop3_err",   32'(err), 32'd0);

    // Asynchronous reset mid-stream, observed before the next edge
    cyc(1, 0, 12'h111);
    cyc(1, 0, 12'h222);
    cyc(1, 0, 12'h333);
    chk("mid_pre_count", 32'(count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_top",   32'(top_addr), 32'h000);
    chk("mid_rst_err",   32'(err), 32'd0);
    #2 rst = 1'b0;

    // Fill to full, then overflow
    for (int i = 1; i <= 8; i++) cyc(1, 0, pc_t'(i * 16));
    chk("fill_full",  32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_top",   32'(top_addr), 32'h080);
    chk("fill_err",   32'(err), 32'd0);
    cyc(1, 0, 12'hFFF);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_top",   32'(top_addr), 32'h080);
    chk("ovf_err",   32'(err), 32'(ERR_EN));

    // Replace on full stack: legal, err unchanged
    cyc(1, 1, 12'h123);
    chk("replfull_count", 32'(count), 32'd8);
    chk("replfull_top",   32'(top_addr), 32'h123);
    chk("replfull_err",   32'(err), 32'(ERR_EN));

    // Drain: lower entries must be intact
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, 12'h000);
      chk($sformatf("drain%0d_top", k), 32'(top_addr), 32'((8 - k) * 16));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_err",   32'(err), 32'(ERR_EN));

    // Underflow on a freshly reset stack
    do_reset();
    chk("clr_err", 32'(err), 32'd0);
    cyc(0, 1, 12'h000);
    chk("udf_count", 32'(count), 32'd0);
    chk("udf_top",   32'(top_addr), 32'h000);
    chk("udf_err",   32'(err), 32'(ERR_EN));

    // Replace semantics, and push&pop on empty acting as push
    do_reset();
    cyc(1, 0, 12'h0AA);
    cyc(1, 1, 12'h0BB);
    chk("repl_count", 32'(count), 32'd1);
    chk("repl_top",   32'(top_addr), 32'h0BB);
    cyc(0, 1, 12'h000);
    chk("repl_pop_empty", 32'(empty), 32'd1);
    cyc(1, 1, 12'h0CC);
    chk("pp_empty_count", 32'(count), 32'd1);
    chk("pp_empty_top",   32'(top_addr), 32'h0CC);
    chk("pp_empty_err",   32'(err), 32'd0);

    // Idle cycle holds state
    cyc(0, 0, 12'h555);
    chk("hold_count", 32'(count), 32'd1);
    chk("hold_top",   32'(top_addr), 32'h0CC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
